// File: rtl/nibble_word_serializer.sv
// nibble_word_serializer
//   Accepts one packed word of WIDTH 4-bit nibbles over a valid/ready handshake
//   and emits its nibbles one per beat on a valid/ready stream with a last marker.
//   Nibble order is index 0 first, or index WIDTH-1 first when MSB_FIRST is set.
//   The final beat of a word can accept the next word, so back-to-back words
//   stream with no idle cycle between them.
//
// Ports
//   clk         clock
//   reset       synchronous reset, active high
//   in_valid    in_data holds a word to transfer
//   in_ready    serializer can accept a word this cycle (combinational)
//   in_data     packed nibble word, [WIDTH-1:0][3:0]
//   out_valid   out_nibble/out_last/out_index are valid (registered)
//   out_ready   consumer accepts the current nibble
//   out_nibble  current nibble, IDLE_VALUE when out_valid is low (registered)
//   out_last    current nibble is the final one of the word (registered)
//   out_index   nibble index within in_data of the current nibble (registered)
module nibble_word_serializer #(
  parameter int unsigned WIDTH      = 4,
  parameter logic [3:0]  IDLE_VALUE = 4'hF,
  parameter bit          MSB_FIRST  = 1'b0,
  localparam int unsigned IW        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0][3:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             out_nibble,
  output logic                   out_last,
  output logic [IW-1:0]          out_index
);

  localparam logic [IW-1:0] LAST_CNT = IW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0][3:0]  data_q, data_d;
  logic [IW-1:0]          cnt_q, cnt_d;
  logic                   out_valid_q, out_valid_d;
  logic [3:0]             out_nibble_q, out_nibble_d;
  logic                   out_last_q, out_last_d;
  logic [IW-1:0]          out_index_q, out_index_d;

  logic                   in_ready_c;
  logic                   accept;
  logic                   beat;
  logic [IW-1:0]          idx_d;

  always_comb begin
    in_ready_c = (state_q == IDLE) || ((state_q == SEND) && out_ready && out_last_q);
    accept     = in_valid && in_ready_c;
    beat       = out_valid_q && out_ready;

    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          data_d  = in_data;
          cnt_d   = '0;
        end
      end
      SEND: begin
        if (beat) begin
          if (!out_last_q) begin
            cnt_d = cnt_q + 1'b1;
          end else if (accept) begin
            data_d = in_data;
            cnt_d  = '0;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are derived from the next state/word/counter so they are
    // registered alongside them; a stall leaves those unchanged, which keeps
    // every out_* signal stable without a separate hold path.
    idx_d        = MSB_FIRST ? (LAST_CNT - cnt_d) : cnt_d;
    out_valid_d  = (state_d == SEND);
    out_nibble_d = out_valid_d ? data_d[idx_d] : IDLE_VALUE;
    out_last_d   = out_valid_d && (cnt_d == LAST_CNT);
    out_index_d  = out_valid_d ? idx_d : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      data_q       <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_nibble_q <= IDLE_VALUE;
      out_last_q   <= 1'b0;
      out_index_q  <= '0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_nibble_q <= out_nibble_d;
      out_last_q   <= out_last_d;
      out_index_q  <= out_index_d;
    end
  end

  assign in_ready   = in_ready_c;
  assign out_valid  = out_valid_q;
  assign out_nibble = out_nibble_q;
  assign out_last   = out_last_q;
  assign out_index  = out_index_q;

endmodule
